issp_vector_queue: RTL

Command/vector queue directly upstream of the M8C ISSP bit engine. Buffers SENDVEC/EXEC requests from the host bus side, issues them one at a time to the engine through a start/busy handshake, and captures each read-back vector into a result FIFO. The host can therefore stream vectors without polling engine status between transfers.

---
 rtl/issp_vector_queue.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/issp_vector_queue.sv
// Command/vector queue in front of the M8C ISSP bit engine: buffers SENDVEC/EXEC
// requests, issues them one at a time via start/busy, and collects read-back vectors.
module issp_vector_queue #(
  parameter int DEPTH = 8,
  parameter int VEC_W = 22,
  parameter int TMO   = 15
) (
  input  logic                   osc,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic                   wr_exec,
  input  logic [VEC_W-1:0]       wr_vector,
  input  logic [VEC_W-1:0]       wr_mask,
  output logic                   cmd_full,
  output logic [$clog2(DEPTH):0] cmd_level,
  output logic                   eng_start,
  output logic [7:0]             eng_cmd,
  output logic [VEC_W-1:0]       eng_vector,
  output logic [VEC_W-1:0]       eng_mask,
  input  logic                   eng_busy,
  input  logic [VEC_W-1:0]       eng_rx_vector,
  input  logic                   res_rd,
  output logic                   res_valid,
  output logic [VEC_W-1:0]       res_data,
  output logic [$clog2(DEPTH):0] res_level,
  input  logic                   flush,
  output logic                   err_overflow,
  output logic                   err_timeout,
  input  logic                   err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TMO + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [7:0]    CMD_SENDVEC = 8'd3;
  localparam logic [7:0]    CMD_EXEC    = 8'd4;
  localparam logic [AW:0]   LVL_ONE     = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL    = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_TMO     = CW'(TMO);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             engStart_q, engStart_d;
  logic [7:0]       engCmd_q, engCmd_d;
  logic [VEC_W-1:0] engVec_q, engVec_d;
  logic [VEC_W-1:0] engMask_q, engMask_d;
  logic             expect_q, expect_d;
  logic             discard_q, discard_d;
  logic             errOvf_q, errOvf_d;
  logic             errTmo_q, errTmo_d;

  logic             cmdExecMem_q [DEPTH];
  logic [VEC_W-1:0] cmdVecMem_q  [DEPTH];
  logic [VEC_W-1:0] cmdMaskMem_q [DEPTH];
  logic [AW-1:0]    cmdWrPtr_q, cmdWrPtr_d;
  logic [AW-1:0]    cmdRdPtr_q, cmdRdPtr_d;
  logic [AW:0]      cmdLevel_q, cmdLevel_d;

  logic [VEC_W-1:0] resMem_q [DEPTH];
  logic [AW-1:0]    resWrPtr_q, resWrPtr_d;
  logic [AW-1:0]    resRdPtr_q, resRdPtr_d;
  logic [AW:0]      resLevel_q, resLevel_d;

  logic             cmdFullInt, cmdEmpty, resFull, resNotEmpty;
  logic             headExec, headExpects;
  logic [VEC_W-1:0] headVec, headMask;
  logic             cmdPush, cmdPop, resPush, resPop, tmoHit;

  assign cmdFullInt  = (cmdLevel_q == LVL_FULL);
  assign cmdEmpty    = (cmdLevel_q == '0);
  assign resFull     = (resLevel_q == LVL_FULL);
  assign resNotEmpty = (resLevel_q != '0);

  assign headExec    = cmdExecMem_q[cmdRdPtr_q];
  assign headVec     = cmdVecMem_q[cmdRdPtr_q];
  assign headMask    = cmdMaskMem_q[cmdRdPtr_q];
  assign headExpects = !headExec && (headMask != '0);

  // Full/empty come from registered levels, so a same-cycle pop never makes room for a push.
  assign cmdPush = wr_en && !flush && !cmdFullInt;
  assign cmdPop  = (state_q == IDLE) && !cmdEmpty && !flush && (!resFull || !headExpects);
  assign resPush = (state_q == DONE) && !eng_busy && expect_q && !discard_q && !flush;
  assign resPop  = res_rd && resNotEmpty && !flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    engStart_d = 1'b0;
    engCmd_d   = engCmd_q;
    engVec_d   = engVec_q;
    engMask_d  = engMask_q;
    expect_d   = expect_q;
    discard_d  = discard_q;
    tmoHit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmdPop) begin
          state_d   = START;
          engCmd_d  = headExec ? CMD_EXEC : CMD_SENDVEC;
          engVec_d  = headVec;
          engMask_d = headMask;
          expect_d  = headExpects;
          discard_d = 1'b0;
        end
      end
      START: begin
        engStart_d = 1'b1;
        cnt_d      = '0;
        state_d    = ACK;
      end
      ACK: begin
        if (eng_busy) begin
          state_d = DONE;
        end else if (cnt_q == CNT_TMO) begin
          tmoHit  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        if (!eng_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush lets the in-flight transfer finish but its read-back must not land.
    if (flush && (state_q != IDLE)) begin
      discard_d = 1'b1;
    end
  end

  always_comb begin
    cmdWrPtr_d = cmdWrPtr_q;
    cmdRdPtr_d = cmdRdPtr_q;
    cmdLevel_d = cmdLevel_q;
    resWrPtr_d = resWrPtr_q;
    resRdPtr_d = resRdPtr_q;
    resLevel_d = resLevel_q;
    if (cmdPush) cmdWrPtr_d = cmdWrPtr_q + PTR_ONE;
    if (cmdPop)  cmdRdPtr_d = cmdRdPtr_q + PTR_ONE;
    case ({cmdPush, cmdPop})
      2'b10:   cmdLevel_d = cmdLevel_q + LVL_ONE;
      2'b01:   cmdLevel_d = cmdLevel_q - LVL_ONE;
      default: cmdLevel_d = cmdLevel_q;
    endcase
    if (resPush) resWrPtr_d = resWrPtr_q + PTR_ONE;
    if (resPop)  resRdPtr_d = resRdPtr_q + PTR_ONE;
    case ({resPush, resPop})
      2'b10:   resLevel_d = resLevel_q + LVL_ONE;
      2'b01:   resLevel_d = resLevel_q - LVL_ONE;
      default: resLevel_d = resLevel_q;
    endcase
    if (flush) begin
      cmdWrPtr_d = '0;
      cmdRdPtr_d = '0;
      cmdLevel_d = '0;
      resWrPtr_d = '0;
      resRdPtr_d = '0;
      resLevel_d = '0;
    end
  end

  // err_clr wins over an error raised in the same cycle.
  always_comb begin
    errOvf_d = errOvf_q | (wr_en && !flush && cmdFullInt);
    errTmo_d = errTmo_q | tmoHit;
    if (err_clr) begin
      errOvf_d = 1'b0;
      errTmo_d = 1'b0;
    end
  end

  always_ff @(posedge osc) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      engStart_q <= 1'b0;
      engCmd_q   <= '0;
      engVec_q   <= '0;
      engMask_q  <= '0;
      expect_q   <= 1'b0;
      discard_q  <= 1'b0;
      errOvf_q   <= 1'b0;
      errTmo_q   <= 1'b0;
      cmdWrPtr_q <= '0;
      cmdRdPtr_q <= '0;
      cmdLevel_q <= '0;
      resWrPtr_q <= '0;
      resRdPtr_q <= '0;
      resLevel_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      engStart_q <= engStart_d;
      engCmd_q   <= engCmd_d;
      engVec_q   <= engVec_d;
      engMask_q  <= engMask_d;
      expect_q   <= expect_d;
      discard_q  <= discard_d;
      errOvf_q   <= errOvf_d;
      errTmo_q   <= errTmo_d;
      cmdWrPtr_q <= cmdWrPtr_d;
      cmdRdPtr_q <= cmdRdPtr_d;
      cmdLevel_q <= cmdLevel_d;
      resWrPtr_q <= resWrPtr_d;
      resRdPtr_q <= resRdPtr_d;
      resLevel_q <= resLevel_d;
    end
  end

  always_ff @(posedge osc) begin
    if (cmdPush) begin
      cmdExecMem_q[cmdWrPtr_q] <= wr_exec;
      cmdVecMem_q[cmdWrPtr_q]  <= wr_vector;
      cmdMaskMem_q[cmdWrPtr_q] <= wr_mask;
    end
    if (resPush) begin
      resMem_q[resWrPtr_q] <= eng_rx_vector;
    end
  end

  assign cmd_full     = cmdFullInt;
  assign cmd_level    = cmdLevel_q;
  assign eng_start    = engStart_q;
  assign eng_cmd      = engCmd_q;
  assign eng_vector   = engVec_q;
  assign eng_mask     = engMask_q;
  assign res_valid    = resNotEmpty;
  assign res_data     = resNotEmpty ? resMem_q[resRdPtr_q] : '0;
  assign res_level    = resLevel_q;
  assign err_overflow = errOvf_q;
  assign err_timeout  = errTmo_q;

endmodule
